// File: rtl/online_div_ctrl.sv
// rtl/online_div_ctrl.sv - iteration sequencer for the online (MSDF) divider
// Sequences INIT (online delay) and RUN (digit recurrence) and registers the SDVM digit select.
module online_div_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DELTA      = 3,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       q_sel,
  output logic             in_req,
  output logic             in_zero,
  output logic             res_clr,
  output logic             q_valid,
  output logic [1:0]       q_digit,
  output logic [1:0]       sdvm_sel,
  output logic [CNT_W-1:0] iter,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DELTA - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(DELTA + NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] N_CNT     = CNT_W'(NUM_DIGITS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sdvm_sel_q, sdvm_sel_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sdvm_sel_q <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sdvm_sel_q <= sdvm_sel_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sdvm_sel_d = 2'b00;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INIT_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d      = cnt_q + 1'b1;
        sdvm_sel_d = q_digit;
        if (q_sel == 2'b11) err_d = 1'b1;
        if (cnt_q == RUN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every transition but leaves a sticky error in place.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      sdvm_sel_d = 2'b00;
    end
  end

  always_comb begin
    busy     = (state_q == S_INIT) || (state_q == S_RUN);
    done     = (state_q == S_DONE);
    in_req   = busy && (cnt_q < N_CNT);
    in_zero  = busy && (cnt_q >= N_CNT);
    res_clr  = busy && (cnt_q == '0);
    iter     = busy ? cnt_q : '0;
    q_valid  = (state_q == S_RUN);
    q_digit  = (q_valid && q_sel != 2'b11) ? q_sel : 2'b00;
    sdvm_sel = sdvm_sel_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_online_div_ctrl.sv
// tb/tb_online_div_ctrl.sv - directed plus randomized checks of online_div_ctrl against a timing model
module tb_online_div_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [1:0] q_sel;

  logic       in_req0, in_zero0, res_clr0, q_valid0, busy0, done0, err0;
  logic [1:0] q_digit0, sdvm_sel0;
  logic [3:0] iter0;
  logic       in_req1, in_zero1, res_clr1, q_valid1, busy1, done1, err1;
  logic [1:0] q_digit1, sdvm_sel1;
  logic [1:0] iter1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  online_div_ctrl #(.NUM_DIGITS(8), .DELTA(3), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q_sel(q_sel),
    .in_req(in_req0), .in_zero(in_zero0), .res_clr(res_clr0), .q_valid(q_valid0),
    .q_digit(q_digit0), .sdvm_sel(sdvm_sel0), .iter(iter0), .busy(busy0),
    .done(done0), .err(err0)
  );

  online_div_ctrl #(.NUM_DIGITS(1), .DELTA(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q_sel(q_sel),
    .in_req(in_req1), .in_zero(in_zero1), .res_clr(res_clr1), .q_valid(q_valid1),
    .q_digit(q_digit1), .sdvm_sel(sdvm_sel1), .iter(iter1), .busy(busy1),
    .done(done1), .err(err1)
  );

  // {busy, done, in_req, in_zero, res_clr, q_valid, q_digit, sdvm_sel, iter, err}
  logic [14:0] obs [2];
  assign obs[0] = {busy0, done0, in_req0, in_zero0, res_clr0, q_valid0, q_digit0, sdvm_sel0, iter0, err0};
  assign obs[1] = {busy1, done1, in_req1, in_zero1, res_clr1, q_valid1, q_digit1, sdvm_sel1, 2'b00, iter1, err1};

  // Model: ph = cycles since start acceptance (0 = idle), plus sticky err and the lagged digit select.
  int         nd [2] = '{8, 1};
  int         dl [2] = '{3, 1};
  int         ph [2];
  logic       err_m [2];
  logic [1:0] sdvm_m [2];

  function automatic logic [14:0] exp_vec(int i);
    int         p = ph[i];
    int         n = nd[i];
    int         d = dl[i];
    logic       b, qv;
    logic [1:0] qd;
    logic [3:0] it;
    b  = (p >= 1) && (p <= d + n);
    qv = (p >= d + 1) && (p <= d + n);
    qd = (qv && q_sel != 2'b11) ? q_sel : 2'b00;
    it = b ? 4'(p - 1) : 4'd0;
    return {b, (p == d + n + 1), b && (p - 1 < n), b && (p - 1 >= n), (p == 1), qv, qd,
            sdvm_m[i], it, err_m[i]};
  endfunction

  task automatic chk(string tag, int i, logic [3:0] o, logic [3:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h t=%0t", tag, i, o, e, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [14:0] o, e;
      o = obs[i];
      e = exp_vec(i);
      chk("busy",     i, {3'b0, o[14]}, {3'b0, e[14]});
      chk("done",     i, {3'b0, o[13]}, {3'b0, e[13]});
      chk("in_req",   i, {3'b0, o[12]}, {3'b0, e[12]});
      chk("in_zero",  i, {3'b0, o[11]}, {3'b0, e[11]});
      chk("res_clr",  i, {3'b0, o[10]}, {3'b0, e[10]});
      chk("q_valid",  i, {3'b0, o[9]},  {3'b0, e[9]});
      chk("q_digit",  i, {2'b0, o[8:7]}, {2'b0, e[8:7]});
      chk("sdvm_sel", i, {2'b0, o[6:5]}, {2'b0, e[6:5]});
      chk("iter",     i, o[4:1], e[4:1]);
      chk("err",      i, {3'b0, o[0]}, {3'b0, e[0]});
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int         p = ph[i];
      int         last = dl[i] + nd[i];
      logic       qv;
      logic [1:0] qd;
      qv = (p >= dl[i] + 1) && (p <= last);
      qd = (qv && q_sel != 2'b11) ? q_sel : 2'b00;
      if (rst) begin
        ph[i] = 0; err_m[i] = 1'b0; sdvm_m[i] = 2'b00;
      end else begin
        if (qv && q_sel == 2'b11) err_m[i] = 1'b1;
        if (abort && p != 0) begin
          ph[i] = 0; sdvm_m[i] = 2'b00;
        end else begin
          sdvm_m[i] = qv ? qd : 2'b00;
          if (p == 0) begin
            if (start) begin ph[i] = 1; err_m[i] = 1'b0; end
          end else if (p == last + 1) ph[i] = 0;
          else ph[i] = p + 1;
        end
      end
    end
  endtask

  // One clock: drive, check current outputs, advance model across the edge.
  task automatic cyc(logic st, logic ab, logic r, logic [1:0] qs);
    start = st; abort = ab; rst = r; q_sel = qs;
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_legal(int n, logic st);
    for (int k = 0; k < n; k++) cyc(st, 1'b0, 1'b0, 2'($urandom_range(0, 2)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b0; abort = 1'b0; rst = 1'b1; q_sel = 2'b00;
    for (int i = 0; i < 2; i++) begin ph[i] = 0; err_m[i] = 1'b0; sdvm_m[i] = 2'b00; end
    @(posedge clk);
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 2'b00);

    // plain operation, q_sel = +1 throughout
    cyc(1'b1, 1'b0, 1'b0, 2'b10);
    for (int k = 0; k < 13; k++) cyc(1'b0, 1'b0, 1'b0, 2'b10);

    // random legal digit stream
    cyc(1'b1, 1'b0, 1'b0, 2'b00);
    run_legal(13, 1'b0);

    // illegal digit on third RUN cycle of the N=8 instance, then a clearing start
    cyc(1'b1, 1'b0, 1'b0, 2'b00);
    for (int k = 1; k <= 13; k++) cyc(1'b0, 1'b0, 1'b0, (k == 6) ? 2'b11 : 2'b01);
    cyc(1'b1, 1'b0, 1'b0, 2'b00);
    run_legal(13, 1'b0);

    // abort at cycle 6, restart at cycle 7
    cyc(1'b1, 1'b0, 1'b0, 2'b10);
    run_legal(5, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'b10);
    cyc(1'b1, 1'b0, 1'b0, 2'b10);
    run_legal(14, 1'b0);

    // start pulses while busy are ignored
    cyc(1'b1, 1'b0, 1'b0, 2'b10);
    for (int k = 1; k <= 13; k++) cyc((k == 2) || (k == 5), 1'b0, 1'b0, 2'b10);

    // start held high: back-to-back operations
    run_legal(30, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 2'b00);
    run_legal(13, 1'b0);

    // reset mid-RUN, then a fresh start
    cyc(1'b1, 1'b0, 1'b0, 2'b10);
    run_legal(7, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 2'b10);
    cyc(1'b0, 1'b0, 1'b0, 2'b10);
    cyc(1'b1, 1'b0, 1'b0, 2'b10);
    run_legal(14, 1'b0);

    // random mix of start/abort/rst/q_sel including illegal digits
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
          2'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
